// File: rtl/coef_bank_arbiter.sv
// coef_bank_arbiter: owns the 64x16 coefficient bank, arbitrates FIR reads against host writes.
// Optional even-parity storage/check enabled by defining COEF_BANK_PARITY_EN.
module coef_bank_arbiter #(
  parameter int ADDR_W      = 6,
  parameter int DATA_W      = 16,
  parameter int WR_MAX_WAIT = 4
) (
  input  logic              clk_b,
  input  logic              rst,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  input  logic              host_wr,
  output logic [DATA_W-1:0] host_rdata,
  input  logic              fir_req,
  input  logic [ADDR_W-1:0] fir_addr,
  output logic              fir_gnt,
  output logic [DATA_W-1:0] fir_rdata,
  output logic              fir_rvalid,
  output logic              ready,
  output logic              wr_ovf,
  output logic              par_err
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int WCW   = $clog2(WR_MAX_WAIT + 1);
  localparam logic [ADDR_W:0] LAST  = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [WCW-1:0]  WMAX  = WCW'(WR_MAX_WAIT);
`ifdef COEF_BANK_PARITY_EN
  localparam int RAM_W = DATA_W + 1;
`else
  localparam int RAM_W = DATA_W;
`endif

  typedef enum logic {INIT, RUN} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W:0]   ptr_q, ptr_d;
  logic              pend_v_q;
  logic [ADDR_W-1:0] pend_a_q;
  logic [DATA_W-1:0] pend_d_q;
  logic [WCW-1:0]    wcnt_q;
  logic              ovf_q;
  logic              rvalid_q;
  logic [DATA_W-1:0] frd_q;
  logic [DATA_W-1:0] hrd_q;

  logic [RAM_W-1:0]  mem_q [DEPTH];

  logic              forced;
  logic              we;
  logic              gnt;
  logic              refresh;
  logic              drain;
  logic              capture;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic [RAM_W-1:0]  wword;
  logic [ADDR_W-1:0] raddr;
  logic [RAM_W-1:0]  ram_rd;

  assign forced  = pend_v_q && (wcnt_q == WMAX);
  assign capture = host_wr && (!pend_v_q || drain);

  // Next state and the single RAM access chosen for this cycle
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    we      = 1'b0;
    gnt     = 1'b0;
    refresh = 1'b0;
    drain   = 1'b0;
    waddr   = pend_a_q;
    wdata   = pend_d_q;
    if (!rst) begin
      unique case (state_q)
        INIT: begin
          we    = 1'b1;
          waddr = ptr_q[ADDR_W-1:0];
          wdata = '0;
          ptr_d = ptr_q + 1'b1;
          if (ptr_q == LAST) state_d = RUN;
        end
        RUN: begin
          if (forced) begin
            we    = 1'b1;
            drain = 1'b1;
          end else if (fir_req) begin
            gnt = 1'b1;
          end else if (pend_v_q) begin
            we    = 1'b1;
            drain = 1'b1;
          end else begin
            refresh = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef COEF_BANK_PARITY_EN
  assign wword = {^wdata, wdata};
`else
  assign wword = wdata;
`endif

  assign raddr  = gnt ? fir_addr : host_addr;
  assign ram_rd = mem_q[raddr];

  // State register and init sweep pointer
  always_ff @(posedge clk_b) begin
    if (rst) begin
      state_q <= INIT;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Bank storage, no reset: the init sweep clears it
  always_ff @(posedge clk_b) begin
    if (we) mem_q[waddr] <= wword;
  end

  // Pending write buffer, wait counter and overflow flag
  always_ff @(posedge clk_b) begin
    if (rst) begin
      pend_v_q <= 1'b0;
      pend_a_q <= '0;
      pend_d_q <= '0;
      wcnt_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (capture) begin
        pend_v_q <= 1'b1;
        pend_a_q <= host_addr;
        pend_d_q <= host_wdata;
      end else if (drain) begin
        pend_v_q <= 1'b0;
      end
      if (host_wr && !capture) ovf_q <= 1'b1;
      if (drain) wcnt_q <= '0;
      else if (pend_v_q && wcnt_q != WMAX) wcnt_q <= wcnt_q + 1'b1;
    end
  end

  // Read data capture for FIR and host paths
  always_ff @(posedge clk_b) begin
    if (rst) begin
      rvalid_q <= 1'b0;
      frd_q    <= '0;
      hrd_q    <= '0;
    end else begin
      rvalid_q <= gnt;
      if (gnt) frd_q <= ram_rd[DATA_W-1:0];
      if (refresh) hrd_q <= ram_rd[DATA_W-1:0];
    end
  end

`ifdef COEF_BANK_PARITY_EN
  logic par_q;

  // Sticky parity error, visible alongside fir_rvalid
  always_ff @(posedge clk_b) begin
    if (rst) par_q <= 1'b0;
    else if (gnt && (^ram_rd)) par_q <= 1'b1;
  end

  assign par_err = par_q;
`else
  assign par_err = 1'b0;
`endif

  assign fir_gnt    = gnt;
  assign fir_rdata  = frd_q;
  assign fir_rvalid = rvalid_q;
  assign host_rdata = hrd_q;
  assign ready      = (state_q == RUN);
  assign wr_ovf     = ovf_q;

endmodule

// File: tb/tb_coef_bank_arbiter.sv
// tb_coef_bank_arbiter: directed vectors, FIR read data checked by a scoreboard monitor.
// Define COEF_BANK_PARITY_EN to also exercise the parity check.
module tb_coef_bank_arbiter;

  localparam int AW = 6;
  localparam int DW = 16;

  logic          clk_b = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] host_addr = '0;
  logic [DW-1:0] host_wdata = '0;
  logic          host_wr = 1'b0;
  logic [DW-1:0] host_rdata;
  logic          fir_req = 1'b0;
  logic [AW-1:0] fir_addr = '0;
  logic          fir_gnt;
  logic [DW-1:0] fir_rdata;
  logic          fir_rvalid;
  logic          ready;
  logic          wr_ovf;
  logic          par_err;

  int vectors = 0;
  int miscompares = 0;
  logic [DW-1:0] exp_q[$];

  coef_bank_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WR_MAX_WAIT(4)) dut (
    .clk_b(clk_b), .rst(rst),
    .host_addr(host_addr), .host_wdata(host_wdata), .host_wr(host_wr),
    .host_rdata(host_rdata),
    .fir_req(fir_req), .fir_addr(fir_addr), .fir_gnt(fir_gnt),
    .fir_rdata(fir_rdata), .fir_rvalid(fir_rvalid),
    .ready(ready), .wr_ovf(wr_ovf), .par_err(par_err)
  );

  always #5 clk_b = ~clk_b;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every fir_rvalid pops one expected word
  always @(negedge clk_b) begin : mon
    logic [DW-1:0] e;
    if (fir_rvalid) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL fir_rvalid_unexpected: got %0h expected none",
                 fir_rdata);
      end else begin
        e = exp_q.pop_front();
        chk("fir_rdata", {16'h0, fir_rdata}, {16'h0, e});
      end
    end
  end

  task automatic step();
    @(posedge clk_b);
    #1;
  endtask

  task automatic host_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    host_wr = 1'b1;
    host_addr = a;
    host_wdata = d;
    step();
    host_wr = 1'b0;
  endtask

  task automatic fir_read(input logic [AW-1:0] a, input logic [DW-1:0] e);
    bit got = 1'b0;
    fir_req = 1'b1;
    fir_addr = a;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk_b);
      if (fir_gnt) begin
        exp_q.push_back(e);
        got = 1'b1;
      end
      step();
    end
    fir_req = 1'b0;
    if (!got) chk("fir_gnt_timeout", 32'd0, 32'd1);
    step();
  endtask

  // Run fir_req on addr 31 (holding zero) and score every grant
  task automatic fir_cycle_push();
    @(negedge clk_b);
    if (fir_gnt) exp_q.push_back('0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int bad;
    int zeros;
    int zpos;
    bit rdy;

    // Reset values
    rst = 1'b1;
    fir_req = 1'b1;
    step();
    @(negedge clk_b);
    chk("rst_fir_gnt", {31'd0, fir_gnt}, 32'd0);
    chk("rst_fir_rvalid", {31'd0, fir_rvalid}, 32'd0);
    chk("rst_fir_rdata", {16'd0, fir_rdata}, 32'd0);
    chk("rst_host_rdata", {16'd0, host_rdata}, 32'd0);
    chk("rst_ready", {31'd0, ready}, 32'd0);
    chk("rst_wr_ovf", {31'd0, wr_ovf}, 32'd0);
    fir_req = 1'b0;
    step();
    rst = 1'b0;

    // ready low for 64 cycles, high in cycle 65
    bad = 0;
    for (int i = 1; i <= 64; i++) begin
      @(negedge clk_b);
      if (ready) bad++;
    end
    chk("ready_low_during_init", bad, 0);
    @(negedge clk_b);
    chk("ready_cycle_65", {31'd0, ready}, 32'd1);
    step();

    // Cleared bank at both ends and the middle
    fir_read(6'd0, 16'h0000);
    fir_read(6'd31, 16'h0000);
    fir_read(6'd63, 16'h0000);

    // Host write with FIR idle, then read-back through refresh
    host_write(6'd5, 16'hABCD);
    step();
    step();
    @(negedge clk_b);
    chk("host_rdata_a5", {16'd0, host_rdata}, 32'h0000ABCD);
    step();
    fir_read(6'd5, 16'hABCD);

    // Back-to-back writes accepted when FIR is idle
    host_write(6'd63, 16'h5A5A);
    host_write(6'd0, 16'h0001);
    step();
    chk("wr_ovf_b2b_ok", {31'd0, wr_ovf}, 32'd0);
    fir_read(6'd63, 16'h5A5A);
    fir_read(6'd0, 16'h0001);

    // Bounded wait under continuous FIR traffic
    fir_req = 1'b1;
    fir_addr = 6'd31;
    host_wr = 1'b1;
    host_addr = 6'd10;
    host_wdata = 16'h1234;
    zeros = 0;
    zpos = -1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk_b);
      if (fir_gnt) exp_q.push_back('0);
      else begin
        zeros++;
        zpos = c;
      end
      step();
      host_wr = 1'b0;
    end
    fir_req = 1'b0;
    chk("forced_gap_count", zeros, 1);
    chk("forced_gap_pos", zpos, 5);
    step();
    fir_read(6'd10, 16'h1234);

    // Second write dropped while the first is still deferred
    fir_req = 1'b1;
    fir_addr = 6'd31;
    host_wr = 1'b1;
    host_addr = 6'd20;
    host_wdata = 16'h1111;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk_b);
      if (fir_gnt) exp_q.push_back('0);
      if (c == 1) chk("wr_ovf_before_drop", {31'd0, wr_ovf}, 32'd0);
      if (c == 2) chk("wr_ovf_after_drop", {31'd0, wr_ovf}, 32'd1);
      step();
      if (c == 0) host_wdata = 16'h2222;
      else host_wr = 1'b0;
    end
    fir_req = 1'b0;
    step();
    step();
    step();
    fir_read(6'd20, 16'h1111);

    // Reset mid-stream with a pending write to addr 63
    fir_req = 1'b1;
    fir_addr = 6'd31;
    host_wr = 1'b1;
    host_addr = 6'd63;
    host_wdata = 16'hBEEF;
    fir_cycle_push();
    step();
    host_wr = 1'b0;
    rst = 1'b1;
    @(negedge clk_b);
    chk("fir_gnt_in_rst", {31'd0, fir_gnt}, 32'd0);
    step();
    rst = 1'b0;
    fir_req = 1'b0;
    @(negedge clk_b);
    chk("ready_after_rst", {31'd0, ready}, 32'd0);
    chk("rvalid_after_rst", {31'd0, fir_rvalid}, 32'd0);
    chk("wr_ovf_after_rst", {31'd0, wr_ovf}, 32'd0);
    rdy = 1'b0;
    for (int i = 0; i < 200 && !rdy; i++) begin
      @(negedge clk_b);
      rdy = ready;
    end
    chk("ready_resweep", {31'd0, rdy}, 32'd1);
    step();
    fir_read(6'd63, 16'h0000);
    fir_read(6'd20, 16'h0000);
    chk("wr_ovf_post_sweep", {31'd0, wr_ovf}, 32'd0);
    chk("par_err_clean", {31'd0, par_err}, 32'd0);

`ifdef COEF_BANK_PARITY_EN
    // Corrupt one stored bit and read it through the FIR port
    dut.mem_q[32] = dut.mem_q[32] ^ 17'h00008;
    fir_req = 1'b1;
    fir_addr = 6'd32;
    @(negedge clk_b);
    chk("par_fir_gnt", {31'd0, fir_gnt}, 32'd1);
    if (fir_gnt) exp_q.push_back(16'h0008);
    step();
    fir_req = 1'b0;
    @(negedge clk_b);
    chk("par_rvalid", {31'd0, fir_rvalid}, 32'd1);
    chk("par_err_set", {31'd0, par_err}, 32'd1);
    step();
    step();
    step();
    chk("par_err_sticky", {31'd0, par_err}, 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk_b);
    chk("par_err_cleared", {31'd0, par_err}, 32'd0);
`endif

    step();
    step();
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
